// File: rtl/scan_index_sequencer.sv
// ---------------------------------------------------------------------------
// scan_index_sequencer
//
// Produces the 3-bit select index for a downstream 3-to-8 one-hot decoder
// that drives LED or keypad rows. The index steps upward through channels
// 0..7. Channels whose mask bit is low are skipped. Each channel is held
// for a programmable dwell time. The block can scan continuously or make
// a single sweep and then stop.
//
// Ports:
//   clk        - system clock; the only clock in the block
//   rst        - synchronous, active-high reset
//   start      - begin scanning; only looked at while idle
//   stop       - abort scanning; the block is idle after the next edge
//   hold       - freeze the dwell counter and sel while high
//   mode       - 0 = continuous scan, 1 = single sweep
//   dwell      - cycles per channel; a value of 0 behaves like 1
//   mask       - per-channel enable; bit i high means channel i is scanned
//   sel        - current channel index (registered)
//   sel_valid  - sel is an actively driven channel (registered)
//   busy       - block is not idle (registered)
//   sweep_done - one-cycle pulse when a full pass over the enabled
//                channels completes (registered)
// ---------------------------------------------------------------------------
module scan_index_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               sweep_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [2:0]         sel_n;
  logic               sel_valid_n;
  logic               busy_n;
  logic               sweep_done_n;

  logic [2:0]         nxt_idx;
  logic [2:0]         low_idx;
  logic               wrap;
  logic [DWELL_W-1:0] load_val;

  // Search upward from cur+1 with wrap-around and return the first enabled
  // channel. The final step (k = 8) lands back on cur itself. That is how a
  // single enabled channel selects itself again.
  function automatic logic [2:0] next_index(input logic [2:0] cur,
                                            input logic [7:0] m);
    logic [2:0] idx;
    logic       found;
    next_index = cur;
    found      = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        next_index = idx;
        found      = 1'b1;
      end
    end
  endfunction

  // Return the lowest enabled channel. Scanning downward lets the lowest
  // set bit be the last one written.
  function automatic logic [2:0] lowest_index(input logic [7:0] m);
    lowest_index = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) lowest_index = 3'(k);
    end
  endfunction

  // Decode the candidate next channel and the counter reload value.
  // A requested dwell of 0 is treated as 1, so the reload value is 0 in
  // both cases. A wrap means the search came back to or below the current
  // index, which is the end of a pass.
  always_comb begin
    nxt_idx  = next_index(sel, mask);
    low_idx  = lowest_index(mask);
    wrap     = (nxt_idx <= sel);
    load_val = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
  end

  // Next-state and next-output logic. By default everything holds and
  // sweep_done drops, so the pulse lasts one cycle. In DWELL the checks run
  // in this order: stop, then hold, then counting down, then the channel
  // advance. This order makes stop beat an advance that falls in the same
  // cycle.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    sel_valid_n  = sel_valid;
    busy_n       = busy;
    sweep_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop && (mask != 8'h00)) begin
          state_n     = DWELL;
          sel_n       = low_idx;
          cnt_n       = load_val;
          sel_valid_n = 1'b1;
          busy_n      = 1'b1;
        end
      end

      DWELL: begin
        if (stop) begin
          state_n     = IDLE;
          sel_valid_n = 1'b0;
          busy_n      = 1'b0;
        end else if (hold) begin
          state_n = DWELL;
        end else if (cnt != '0) begin
          cnt_n = cnt - DWELL_W'(1);
        end else if (mask == 8'h00) begin
          state_n     = IDLE;
          sel_valid_n = 1'b0;
          busy_n      = 1'b0;
        end else if (!wrap) begin
          sel_n = nxt_idx;
          cnt_n = load_val;
        end else if (!mode) begin
          sel_n        = nxt_idx;
          cnt_n        = load_val;
          sweep_done_n = 1'b1;
        end else begin
          state_n      = IDLE;
          sel_valid_n  = 1'b0;
          busy_n       = 1'b0;
          sweep_done_n = 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        sel_valid_n = 1'b0;
        busy_n      = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset is synchronous and overrides every
  // other input, including in the middle of a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 3'd0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      sel_valid  <= sel_valid_n;
      busy       <= busy_n;
      sweep_done <= sweep_done_n;
    end
  end

endmodule

// File: tb/tb_scan_index_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_index_sequencer
//
// Directed testbench for scan_index_sequencer. Every check compares the
// packed observation {sel, sel_valid, busy, sweep_done} with a value
// worked out by hand from the intended scan behaviour.
// ---------------------------------------------------------------------------
module tb_scan_index_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold, mode;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       sel_valid, busy, sweep_done;

  int vectors     = 0;
  int miscompares = 0;

  scan_index_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .mode       (mode),
    .dwell      (dwell),
    .mask       (mask),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Pack the expected observation into the same layout as the DUT outputs.
  function automatic logic [5:0] pack(input int s, input logic v,
                                      input logic b, input logic d);
    return {3'(s), v, b, d};
  endfunction

  // Compare one observation with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [5:0] observed,
                             input logic [5:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got sel/valid/busy/done=%b, want %b",
               tag, observed, expected);
    end
  endtask

  // Drive one set of inputs, then advance one clock. The task returns 1 ns
  // after the rising edge, so the outputs are already stable when sampled.
  task automatic applyStimulus(input logic st, input logic sp, input logic hd,
                               input logic md, input logic [7:0] dw,
                               input logic [7:0] mk);
    start = st;
    stop  = sp;
    hold  = hd;
    mode  = md;
    dwell = dw;
    mask  = mk;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {sel, sel_valid, busy, sweep_done};
  endfunction

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'd0, 8'h00);
    applyStimulus(0, 0, 0, 0, 8'd0, 8'h00);
    checkOutput("reset", obs(), pack(0, 0, 0, 0));
    rst = 1'b0;

    // Single sweep over all channels with dwell 2.
    applyStimulus(1, 0, 0, 1, 8'd2, 8'hFF);
    for (int c = 0; c < 16; c++) begin
      checkOutput($sformatf("sweep_c%0d", c), obs(), pack(c / 2, 1, 1, 0));
      applyStimulus(0, 0, 0, 1, 8'd2, 8'hFF);
    end
    checkOutput("sweep_end", obs(), pack(7, 0, 0, 1));
    applyStimulus(0, 0, 0, 1, 8'd2, 8'hFF);
    checkOutput("sweep_idle", obs(), pack(7, 0, 0, 0));

    // Continuous scan over channels 2, 5, 7 with dwell 0 (behaves as 1).
    applyStimulus(1, 0, 0, 0, 8'd0, 8'b1010_0100);
    for (int c = 0; c < 9; c++) begin
      int s;
      s = (c % 3 == 0) ? 2 : ((c % 3 == 1) ? 5 : 7);
      checkOutput($sformatf("cont_c%0d", c), obs(),
                  pack(s, 1, 1, (c > 0) && (c % 3 == 0)));
      if (c < 8) applyStimulus(0, 0, 0, 0, 8'd0, 8'b1010_0100);
    end
    applyStimulus(0, 1, 0, 0, 8'd0, 8'b1010_0100);
    checkOutput("cont_stop", obs(), pack(7, 0, 0, 0));

    // Only channel 4 enabled, dwell 3: sweep_done pulses every 3 cycles.
    applyStimulus(1, 0, 0, 0, 8'd3, 8'h10);
    for (int c = 0; c < 9; c++) begin
      checkOutput($sformatf("single_c%0d", c), obs(),
                  pack(4, 1, 1, (c > 0) && (c % 3 == 0)));
      if (c < 8) applyStimulus(0, 0, 0, 0, 8'd3, 8'h10);
    end
    applyStimulus(0, 1, 0, 0, 8'd3, 8'h10);
    checkOutput("single_stop", obs(), pack(4, 0, 0, 0));

    // Dwell 4 with hold held for 5 cycles during channel 3. Channel 3
    // occupies cycles 12..20, which is 9 cycles in total.
    applyStimulus(1, 0, 0, 0, 8'd4, 8'hFF);
    for (int c = 0; c < 22; c++) begin
      int s;
      s = (c < 12) ? c / 4 : ((c <= 20) ? 3 : 4);
      checkOutput($sformatf("hold_c%0d", c), obs(), pack(s, 1, 1, 0));
      if (c < 21)
        applyStimulus(0, 0, (c >= 13) && (c <= 17), 0, 8'd4, 8'hFF);
    end
    applyStimulus(0, 1, 0, 0, 8'd4, 8'hFF);
    checkOutput("hold_stop", obs(), pack(4, 0, 0, 0));

    // A start with an empty mask is ignored.
    applyStimulus(1, 0, 0, 0, 8'd1, 8'h00);
    checkOutput("start_mask0", obs(), pack(4, 0, 0, 0));

    // The mask drops to 0 partway through the dwell. The current channel
    // finishes, and the next advance returns to idle with no sweep_done.
    applyStimulus(1, 0, 0, 0, 8'd2, 8'h06);
    checkOutput("mask0_c0", obs(), pack(1, 1, 1, 0));
    applyStimulus(0, 0, 0, 0, 8'd2, 8'h00);
    checkOutput("mask0_c1", obs(), pack(1, 1, 1, 0));
    applyStimulus(0, 0, 0, 0, 8'd2, 8'h00);
    checkOutput("mask0_idle", obs(), pack(1, 0, 0, 0));

    // start and stop asserted together: the block stays idle.
    applyStimulus(1, 1, 0, 0, 8'd2, 8'hFF);
    checkOutput("start_stop", obs(), pack(1, 0, 0, 0));

    // Reset during channel 5, then restart from the lowest enabled channel.
    applyStimulus(1, 0, 0, 0, 8'd1, 8'hFF);
    for (int c = 1; c <= 5; c++) applyStimulus(0, 0, 0, 0, 8'd1, 8'hFF);
    checkOutput("pre_rst_c5", obs(), pack(5, 1, 1, 0));
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'd1, 8'hFF);
    checkOutput("mid_rst", obs(), pack(0, 0, 0, 0));
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, 8'd1, 8'h30);
    checkOutput("restart_c0", obs(), pack(4, 1, 1, 0));
    applyStimulus(0, 0, 0, 0, 8'd1, 8'h30);
    checkOutput("restart_c1", obs(), pack(5, 1, 1, 0));
    applyStimulus(0, 0, 0, 0, 8'd1, 8'h30);
    checkOutput("restart_wrap", obs(), pack(4, 1, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
